rl_agent_step_unit: RTL and testbench

//  Agent-side responder to the learning control unit. For each step request it selects an

---
 rtl/rl_agent_step_unit.sv | 215 +++++++++++++++++++++
 tb/tb_rl_agent_step_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_agent_step_unit.sv
// Agent-side step responder: picks a random or greedy action, moves the agent on the grid,
// and reports state, action, next state and reward with a one-cycle step_valid pulse.
module rl_agent_step_unit #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 7,
    parameter int GOAL_Y  = 7,
    parameter int Q_W     = 16,
    parameter logic signed [15:0] R_STEP = -16'sd1,
    parameter logic signed [15:0] R_WALL = -16'sd10,
    parameter logic signed [15:0] R_GOAL = 16'sd100,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_step_req,
    input  logic                 i_act_select_in,
    input  logic                 i_pos_reset_in,
    input  logic [9:0]           i_random_value_in,
    output logic                 o_q_rd_en,
    output logic [YW+XW+1:0]     o_q_rd_addr,
    input  logic signed [Q_W-1:0] i_q_rd_data,
    output logic                 o_busy,
    output logic [XW-1:0]        o_cur_x,
    output logic [YW-1:0]        o_cur_y,
    output logic [1:0]           o_action_out,
    output logic [XW-1:0]        o_next_x,
    output logic [YW-1:0]        o_next_y,
    output logic [15:0]          o_reward_out,
    output logic                 o_step_valid,
    output logic                 o_goal_reached
);

    localparam logic [XW-1:0] START_XV = XW'(START_X);
    localparam logic [YW-1:0] START_YV = YW'(START_Y);
    localparam logic [XW-1:0] GOAL_XV  = XW'(GOAL_X);
    localparam logic [YW-1:0] GOAL_YV  = YW'(GOAL_Y);
    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_QLAST, S_MOVE, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [XW-1:0]         r_curX;
    logic [YW-1:0]         r_curY;
    logic [XW-1:0]         r_nextX;
    logic [YW-1:0]         r_nextY;
    logic [1:0]            r_action;
    logic [15:0]           r_reward;
    logic                  r_qRdEn;
    logic [YW+XW+1:0]      r_qRdAddr;
    logic                  r_busy;
    logic                  r_stepValid;
    logic                  r_goalReached;
    logic                  r_goalFlag;
    logic signed [Q_W-1:0] r_bestQ;
    logic [1:0]            r_bestIdx;

    logic                  w_rdEn;
    logic [1:0]            w_rdIdx;
    logic                  w_better;
    logic [XW-1:0]         w_candX;
    logic [YW-1:0]         w_candY;
    logic                  w_wall;
    logic                  w_isGoal;
    logic                  w_unusedRnd;

    // Only the low two bits of the random source select an action.
    assign w_unusedRnd = ^i_random_value_in[9:2];
    assign w_better    = i_q_rd_data > r_bestQ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (i_step_req) w_nextState = i_act_select_in ? S_MOVE : S_RD0;
            S_RD0:   w_nextState = S_RD1;
            S_RD1:   w_nextState = S_RD2;
            S_RD2:   w_nextState = S_RD3;
            S_RD3:   w_nextState = S_QLAST;
            S_QLAST: w_nextState = S_MOVE;
            S_MOVE:  w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (i_pos_reset_in) begin
            w_nextState = S_IDLE;
        end
    end

    // Read strobe and index are registered from the state being entered.
    always_comb begin
        w_rdEn  = 1'b0;
        w_rdIdx = 2'd0;
        case (w_nextState)
            S_RD0:   begin w_rdEn = 1'b1; w_rdIdx = 2'd0; end
            S_RD1:   begin w_rdEn = 1'b1; w_rdIdx = 2'd1; end
            S_RD2:   begin w_rdEn = 1'b1; w_rdIdx = 2'd2; end
            S_RD3:   begin w_rdEn = 1'b1; w_rdIdx = 2'd3; end
            default: begin w_rdEn = 1'b0; w_rdIdx = 2'd0; end
        endcase
    end

    always_comb begin
        w_candX = r_curX;
        w_candY = r_curY;
        w_wall  = 1'b0;
        case (r_action)
            2'd0: if (r_curY == '0)   w_wall = 1'b1; else w_candY = r_curY - 1'b1;
            2'd1: if (r_curY == Y_MAX) w_wall = 1'b1; else w_candY = r_curY + 1'b1;
            2'd2: if (r_curX == '0)   w_wall = 1'b1; else w_candX = r_curX - 1'b1;
            default: if (r_curX == X_MAX) w_wall = 1'b1; else w_candX = r_curX + 1'b1;
        endcase
        w_isGoal = !w_wall && (w_candX == GOAL_XV) && (w_candY == GOAL_YV);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_curX        <= START_XV;
            r_curY        <= START_YV;
            r_nextX       <= '0;
            r_nextY       <= '0;
            r_action      <= '0;
            r_reward      <= '0;
            r_qRdEn       <= 1'b0;
            r_qRdAddr     <= '0;
            r_busy        <= 1'b0;
            r_stepValid   <= 1'b0;
            r_goalReached <= 1'b0;
            r_goalFlag    <= 1'b0;
            r_bestQ       <= '0;
            r_bestIdx     <= '0;
        end else begin
            r_qRdEn       <= w_rdEn;
            r_busy        <= (w_nextState != S_IDLE);
            r_stepValid   <= 1'b0;
            r_goalReached <= 1'b0;
            if (w_rdEn) begin
                r_qRdAddr <= {r_curY, r_curX, w_rdIdx};
            end
            if (i_pos_reset_in) begin
                r_curX <= START_XV;
                r_curY <= START_YV;
            end else begin
                // Each Q word arrives one state after its read, so RD1 sees entry 0.
                case (r_state)
                    S_IDLE: begin
                        if (i_step_req && i_act_select_in) begin
                            r_action <= i_random_value_in[1:0];
                        end
                    end
                    S_RD1: begin
                        r_bestQ   <= i_q_rd_data;
                        r_bestIdx <= 2'd0;
                    end
                    S_RD2: begin
                        if (w_better) begin
                            r_bestQ   <= i_q_rd_data;
                            r_bestIdx <= 2'd1;
                        end
                    end
                    S_RD3: begin
                        if (w_better) begin
                            r_bestQ   <= i_q_rd_data;
                            r_bestIdx <= 2'd2;
                        end
                    end
                    S_QLAST: begin
                        r_action <= w_better ? 2'd3 : r_bestIdx;
                    end
                    S_MOVE: begin
                        r_nextX    <= w_candX;
                        r_nextY    <= w_candY;
                        r_goalFlag <= w_isGoal;
                        r_reward   <= w_wall ? R_WALL : (w_isGoal ? R_GOAL : R_STEP);
                    end
                    S_DONE: begin
                        r_stepValid   <= 1'b1;
                        r_goalReached <= r_goalFlag;
                        r_curX        <= r_goalFlag ? START_XV : r_nextX;
                        r_curY        <= r_goalFlag ? START_YV : r_nextY;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_q_rd_en      = r_qRdEn;
    assign o_q_rd_addr    = r_qRdAddr;
    assign o_busy         = r_busy;
    assign o_cur_x        = r_curX;
    assign o_cur_y        = r_curY;
    assign o_action_out   = r_action;
    assign o_next_x       = r_nextX;
    assign o_next_y       = r_nextY;
    assign o_reward_out   = r_reward;
    assign o_step_valid   = r_stepValid;
    assign o_goal_reached = r_goalReached;

endmodule

// File: tb/tb_rl_agent_step_unit.sv
// Scoreboard bench for rl_agent_step_unit: directed steps push expected results,
// negedge monitors pop and compare step outputs and Q-table read addresses.
module tb_rl_agent_step_unit;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stepReq;
    logic               actSel;
    logic               posReset;
    logic [9:0]         rnd;
    logic               qRdEn;
    logic [7:0]         qRdAddr;
    logic signed [15:0] qRdData = '0;
    logic               busy;
    logic [2:0]         curX, curY, nextX, nextY;
    logic [1:0]         action;
    logic [15:0]        reward;
    logic               stepValid;
    logic               goalReached;

    typedef struct {
        logic [1:0]  action;
        logic [2:0]  nx;
        logic [2:0]  ny;
        logic [15:0] reward;
        logic        goal;
        logic [2:0]  cx;
        logic [2:0]  cy;
        int          cycle;
    } exp_t;

    exp_t               sbQ[$];
    logic [7:0]         addrQ[$];
    exp_t               monExp;
    logic [7:0]         monAddr;
    logic signed [15:0] qMem [0:255];
    int                 checks = 0;
    int                 failures = 0;
    int                 cycleCount = 0;
    int                 tbX = 0;
    int                 tbY = 0;

    rl_agent_step_unit dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_step_req        (stepReq),
        .i_act_select_in   (actSel),
        .i_pos_reset_in    (posReset),
        .i_random_value_in (rnd),
        .o_q_rd_en         (qRdEn),
        .o_q_rd_addr       (qRdAddr),
        .i_q_rd_data       (qRdData),
        .o_busy            (busy),
        .o_cur_x           (curX),
        .o_cur_y           (curY),
        .o_action_out      (action),
        .o_next_x          (nextX),
        .o_next_y          (nextY),
        .o_reward_out      (reward),
        .o_step_valid      (stepValid),
        .o_goal_reached    (goalReached)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Q-table model: one-cycle read latency.
    always @(posedge clk) begin
        if (qRdEn) qRdData <= qMem[qRdAddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && stepValid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_step_valid", 32'd1, 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("step_cycle", cycleCount, monExp.cycle);
                checkOutput("action", action, monExp.action);
                checkOutput("next_x", nextX, monExp.nx);
                checkOutput("next_y", nextY, monExp.ny);
                checkOutput("reward", reward, monExp.reward);
                checkOutput("goal_reached", goalReached, monExp.goal);
                checkOutput("cur_x_after", curX, monExp.cx);
                checkOutput("cur_y_after", curY, monExp.cy);
            end
        end
        if (rst_n && qRdEn) begin
            if (addrQ.size() == 0) begin
                checkOutput("unexpected_q_rd", {24'd0, qRdAddr}, 32'hFFFF_FFFF);
            end else begin
                monAddr = addrQ.pop_front();
                checkOutput("q_rd_addr", qRdAddr, monAddr);
            end
        end
    end

    task automatic applyStimulus(input logic act, input logic [9:0] rv, input logic [1:0] expAct,
                                 input int nx, input int ny, input logic [15:0] rew,
                                 input logic goal, input int cx, input int cy);
        exp_t e;
        @(negedge clk);
        e.action = expAct;
        e.nx     = nx[2:0];
        e.ny     = ny[2:0];
        e.reward = rew;
        e.goal   = goal;
        e.cx     = cx[2:0];
        e.cy     = cy[2:0];
        e.cycle  = cycleCount + 1 + (act ? 2 : 7);
        sbQ.push_back(e);
        if (!act) begin
            for (int k = 0; k < 4; k++) addrQ.push_back({tbY[2:0], tbX[2:0], 2'(k)});
        end
        stepReq = 1'b1;
        actSel  = act;
        rnd     = rv;
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b0;
        tbX = cx;
        tbY = cy;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 30);
        checkOutput("idle_timeout", busy, 0);
    endtask

    task automatic walk(input logic [1:0] dir, input int n);
        int nx, ny;
        for (int i = 0; i < n; i++) begin
            nx = tbX + (dir == 2'd3 ? 1 : 0) - (dir == 2'd2 ? 1 : 0);
            ny = tbY + (dir == 2'd1 ? 1 : 0) - (dir == 2'd0 ? 1 : 0);
            applyStimulus(1'b1, {8'hA5, dir}, dir, nx, ny, 16'hFFFF, 1'b0, nx, ny);
            waitIdle();
        end
    endtask

    task automatic doPosReset();
        @(negedge clk);
        posReset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        posReset = 1'b0;
        checkOutput("posreset_cur_x", curX, 0);
        checkOutput("posreset_cur_y", curY, 0);
        tbX = 0;
        tbY = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stepReq = 1'b0; actSel = 1'b0; posReset = 1'b0; rnd = '0;
        for (int i = 0; i < 256; i++) qMem[i] = '0;
        #2;
        checkOutput("rst_q_rd_en", qRdEn, 0);
        checkOutput("rst_q_rd_addr", qRdAddr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cur_x", curX, 0);
        checkOutput("rst_cur_y", curY, 0);
        checkOutput("rst_action", action, 0);
        checkOutput("rst_next_x", nextX, 0);
        checkOutput("rst_next_y", nextY, 0);
        checkOutput("rst_reward", reward, 0);
        checkOutput("rst_step_valid", stepValid, 0);
        checkOutput("rst_goal", goalReached, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random step from (3,3) moving right.
        walk(2'd3, 3);
        walk(2'd1, 3);
        applyStimulus(1'b1, 10'h2A7, 2'd3, 4, 3, 16'hFFFF, 1'b0, 4, 3);
        waitIdle();

        // Walls at the start corner.
        doPosReset();
        applyStimulus(1'b1, 10'h1FC, 2'd0, 0, 0, 16'hFFF6, 1'b0, 0, 0);
        waitIdle();
        applyStimulus(1'b1, 10'h302, 2'd2, 0, 0, 16'hFFF6, 1'b0, 0, 0);
        waitIdle();

        // Greedy with a tie at the top, then negative values.
        walk(2'd3, 2);
        walk(2'd1, 5);
        qMem[8'hA8] = 16'sd5;  qMem[8'hA9] = -16'sd3;
        qMem[8'hAA] = 16'sd9;  qMem[8'hAB] = 16'sd9;
        applyStimulus(1'b0, 10'h003, 2'd2, 1, 5, 16'hFFFF, 1'b0, 1, 5);
        waitIdle();
        qMem[8'hA4] = -16'sd7; qMem[8'hA5] = -16'sd2;
        qMem[8'hA6] = -16'sd9; qMem[8'hA7] = -16'sd2;
        applyStimulus(1'b0, 10'h000, 2'd1, 1, 6, 16'hFFFF, 1'b0, 1, 6);
        waitIdle();

        // Bottom wall, then entering the goal.
        doPosReset();
        walk(2'd1, 7);
        applyStimulus(1'b1, 10'h001, 2'd1, 0, 7, 16'hFFF6, 1'b0, 0, 7);
        waitIdle();
        walk(2'd3, 6);
        applyStimulus(1'b1, 10'h0F3, 2'd3, 7, 7, 16'd100, 1'b1, 0, 0);
        waitIdle();

        // Abort a greedy step in RD2; a step_req alongside pos_reset is ignored.
        walk(2'd3, 1);
        @(negedge clk);
        addrQ.push_back(8'h04); addrQ.push_back(8'h05); addrQ.push_back(8'h06);
        stepReq = 1'b1; actSel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        posReset = 1'b1; stepReq = 1'b1; actSel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_q_rd_en", qRdEn, 0);
        checkOutput("abort_cur_x", curX, 0);
        checkOutput("abort_cur_y", curY, 0);
        posReset = 1'b0; stepReq = 1'b0;
        tbX = 0; tbY = 0;
        repeat (12) @(negedge clk);

        // step_req pulses in RD1 and MOVE must be ignored.
        walk(2'd1, 1);
        applyStimulus(1'b0, 10'h000, 2'd0, 0, 0, 16'hFFFF, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b1; actSel = 1'b1; rnd = 10'h003;
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        stepReq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b0;
        waitIdle();
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of a greedy step.
        walk(2'd3, 1);
        @(negedge clk);
        addrQ.push_back(8'h04); addrQ.push_back(8'h05);
        stepReq = 1'b1; actSel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stepReq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_q_rd_en", qRdEn, 0);
        checkOutput("mid_rst_q_rd_addr", qRdAddr, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_cur_x", curX, 0);
        checkOutput("mid_rst_cur_y", curY, 0);
        checkOutput("mid_rst_action", action, 0);
        checkOutput("mid_rst_next_x", nextX, 0);
        checkOutput("mid_rst_reward", reward, 0);
        checkOutput("mid_rst_step_valid", stepValid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tbX = 0; tbY = 0;
        walk(2'd1, 1);

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", sbQ.size(), 0);
        checkOutput("addr_drained", addrQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
